// File: rtl/freq_gen.sv
// Phase-accumulator square-wave generator with continuous and burst output.
// Tuning words arrive over valid/ready and switch in only at output-cycle boundaries.
module freq_gen #(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned ACC_W        = 32,
    parameter int unsigned BURST_W      = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               burst_mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [ACC_W-1:0]   tw_in,
    input  logic               tw_vld,
    output logic               tw_rdy,
    output logic               clk_out,
    output logic               cyc_pulse,
    output logic               busy,
    output logic [ACC_W-1:0]   tw_cur
);

    if (SYS_CLK_FREQ == 0 || ACC_W < 2 || BURST_W < 1) begin : g_bad_params
        $error("freq_gen: invalid parameters");
    end

    // Half of the accumulator range: a two-cycle output period.
    localparam logic [ACC_W-1:0] TwMax = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   tw_cur_q, tw_cur_d;
    logic [ACC_W-1:0]   tw_pend_q, tw_pend_d;
    logic               pend_q, pend_d;
    logic               burst_q, burst_d;
    logic               pulse_q, pulse_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;

    logic [ACC_W:0] sum;
    logic           wrap;
    logic           last_wrap;
    logic           hs;
    logic           tw_zero;

    assign sum       = {1'b0, acc_q} + {1'b0, tw_cur_q};
    assign wrap      = (state_q != StIdle) && sum[ACC_W];
    assign last_wrap = wrap && burst_q && (cnt_q == BURST_W'(1));
    assign hs        = tw_vld && !pend_q;
    assign tw_zero   = (tw_cur_q == '0);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tw_cur_d  = tw_cur_q;
        tw_pend_d = tw_pend_q;
        pend_d    = pend_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        pulse_d   = wrap;

        // Pending word lands immediately when idle, otherwise only on a wrap.
        if (pend_q && (state_q == StIdle || wrap)) begin
            tw_cur_d = tw_pend_q;
            pend_d   = 1'b0;
        end
        if (hs) begin
            pend_d    = 1'b1;
            tw_pend_d = (tw_in > TwMax) ? TwMax : tw_in;
        end

        unique case (state_q)
            StIdle: begin
                acc_d = '0;
                if (en && !tw_zero && (!burst_mode || burst_len != '0)) begin
                    state_d = StRun;
                    cnt_d   = burst_len;
                    burst_d = burst_mode;
                end
            end
            StRun: begin
                acc_d = sum[ACC_W-1:0];
                if (wrap && burst_q) cnt_d = cnt_q - BURST_W'(1);
                if (last_wrap) begin
                    state_d = StIdle;
                end else if (!en) begin
                    // A frozen accumulator never wraps, so it cannot drain through STOP.
                    state_d = tw_zero ? StIdle : StStop;
                end
            end
            StStop: begin
                acc_d = sum[ACC_W-1:0];
                if (wrap && burst_q) cnt_d = cnt_q - BURST_W'(1);
                if (last_wrap) begin
                    state_d = StIdle;
                end else if (en) begin
                    state_d = StRun;
                end else if (wrap || tw_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) acc_d = '0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            tw_cur_q  <= '0;
            tw_pend_q <= '0;
            pend_q    <= 1'b0;
            burst_q   <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tw_cur_q  <= tw_cur_d;
            tw_pend_q <= tw_pend_d;
            pend_q    <= pend_d;
            burst_q   <= burst_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign clk_out   = acc_q[ACC_W-1];
    assign cyc_pulse = pulse_q;
    assign busy      = (state_q != StIdle);
    assign tw_rdy    = !pend_q;
    assign tw_cur    = tw_cur_q;

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen: directed table, multi-cycle corner sequences, and a randomized
// run against an arithmetic reference model of the generator.
module tb_freq_gen;

    localparam int unsigned AW   = 8;
    localparam int unsigned BW   = 8;
    localparam int          Full = 256;
    localparam int          Half = 128;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          en = 1'b0;
    logic          burst_mode = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic [AW-1:0] tw_in = '0;
    logic          tw_vld = 1'b0;
    logic          tw_rdy;
    logic          clk_out;
    logic          cyc_pulse;
    logic          busy;
    logic [AW-1:0] tw_cur;

    always #5 sys_clk = ~sys_clk;

    freq_gen #(
        .SYS_CLK_FREQ(50_000_000),
        .ACC_W       (AW),
        .BURST_W     (BW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .burst_mode(burst_mode),
        .burst_len (burst_len),
        .tw_in     (tw_in),
        .tw_vld    (tw_vld),
        .tw_rdy    (tw_rdy),
        .clk_out   (clk_out),
        .cyc_pulse (cyc_pulse),
        .busy      (busy),
        .tw_cur    (tw_cur)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as an integer, generator activity as plain flags.
    bit model_on = 1'b0;
    int m_phase, m_tw, m_pw, m_left;
    bit m_pend, m_active, m_drain, m_burst, m_pulse;

    task automatic model_reset();
        m_phase = 0; m_tw = 0; m_pw = 0; m_left = 0;
        m_pend = 0; m_active = 0; m_drain = 0; m_burst = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        int sum, tw_old;
        bit wrap, done, hs;
        tw_old = m_tw;
        sum    = m_phase + m_tw;
        wrap   = m_active && (sum >= Full);
        done   = wrap && m_burst && (m_left == 1);
        hs     = tw_vld && !m_pend;
        m_pulse = wrap;
        if (m_pend && (!m_active || wrap)) begin
            m_tw   = m_pw;
            m_pend = 0;
        end
        if (hs) begin
            m_pend = 1;
            m_pw   = (int'(tw_in) > Half) ? Half : int'(tw_in);
        end
        if (!m_active) begin
            m_phase = 0;
            if (en && tw_old != 0 && (!burst_mode || burst_len != 0)) begin
                m_active = 1;
                m_drain  = 0;
                m_left   = int'(burst_len);
                m_burst  = burst_mode;
            end
        end else begin
            m_phase = sum % Full;
            if (wrap && m_burst) m_left--;
            if (done) m_active = 0;
            else if (m_drain) begin
                if (en) m_drain = 0;
                else if (wrap || tw_old == 0) m_active = 0;
            end else if (!en) begin
                if (tw_old == 0) m_active = 0;
                else m_drain = 1;
            end
            if (!m_active) m_phase = 0;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        if (model_on) model_step();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic load_tw(input int v);
        tw_in  = v[AW-1:0];
        tw_vld = 1'b1;
        step();
        tw_vld = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 600 && busy; k++) step();
        check(name, busy, 0);
    endtask

    typedef struct {
        logic          en;
        logic          bm;
        logic [BW-1:0] bl;
        logic [AW-1:0] twi;
        logic          vld;
        logic          eclk;
        logic          epul;
        logic          ebusy;
        logic          erdy;
        logic [AW-1:0] etw;
    } vec_t;

    function automatic vec_t mk(input int e, input int bm, input int bl, input int twi,
                                input int vld, input int c, input int p, input int b,
                                input int r, input int t);
        vec_t v;
        v.en = e[0]; v.bm = bm[0]; v.bl = bl[BW-1:0]; v.twi = twi[AW-1:0]; v.vld = vld[0];
        v.eclk = c[0]; v.epul = p[0]; v.ebusy = b[0]; v.erdy = r[0]; v.etw = t[AW-1:0];
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        int pulses;

        // en bm bl twi vld | clk pulse busy rdy tw_cur
        tbl[0]  = mk(0, 0, 0, 64, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 64);
        tbl[2]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 1, 64);
        tbl[3]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 1, 64);
        tbl[4]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[5]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[6]  = mk(1, 0, 0, 0,  0, 0, 1, 1, 1, 64);
        tbl[7]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 1, 64);
        tbl[8]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[9]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[10] = mk(1, 0, 0, 0,  0, 0, 1, 1, 1, 64);
        tbl[11] = mk(1, 0, 0, 0,  0, 0, 0, 1, 1, 64);
        tbl[12] = mk(0, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[13] = mk(0, 0, 0, 0,  0, 1, 0, 1, 1, 64);
        tbl[14] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 64);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 64);
        tbl[16] = mk(1, 1, 0, 0,  0, 0, 0, 0, 1, 64);
        tbl[17] = mk(1, 1, 0, 0,  0, 0, 0, 0, 1, 64);

        do_reset();
        check("rst_clk", clk_out, 0);
        check("rst_pulse", cyc_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", tw_rdy, 1);
        check("rst_tw", tw_cur, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; burst_mode = tbl[i].bm; burst_len = tbl[i].bl;
            tw_in = tbl[i].twi; tw_vld = tbl[i].vld;
            step();
            check($sformatf("tbl%0d_clk", i), clk_out, tbl[i].eclk);
            check($sformatf("tbl%0d_pulse", i), cyc_pulse, tbl[i].epul);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
            check($sformatf("tbl%0d_rdy", i), tw_rdy, tbl[i].erdy);
            check($sformatf("tbl%0d_tw", i), tw_cur, tbl[i].etw);
        end
        en = 1'b0; burst_mode = 1'b0; tw_vld = 1'b0;

        // Clamp to Nyquist: period 2
        load_tw(200);
        check("clamp_tw", tw_cur, 128);
        en = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("nyq_clk%0d", k), clk_out, k % 2);
            check($sformatf("nyq_pulse%0d", k), cyc_pulse, (k % 2) == 0);
        end
        en = 1'b0;
        wait_idle("nyq_idle");

        // tw=96: three wraps every eight cycles
        load_tw(96);
        en = 1'b1;
        step();
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            pulses += int'(cyc_pulse);
        end
        check("tw96_pulses", pulses, 9);
        en = 1'b0;
        wait_idle("tw96_idle");

        // Burst of three cycles
        load_tw(64);
        burst_mode = 1'b1; burst_len = 8'd3; en = 1'b1;
        step();
        burst_len = 8'd0;
        check("burst_start_busy", busy, 1);
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            pulses += int'(cyc_pulse);
        end
        check("burst_t11_busy", busy, 1);
        step();
        pulses += int'(cyc_pulse);
        check("burst_t12_pulse", cyc_pulse, 1);
        check("burst_t12_busy", busy, 0);
        check("burst_t12_clk", clk_out, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += int'(cyc_pulse);
        end
        check("burst_pulses", pulses, 3);
        check("burst_len0_busy", busy, 0);
        en = 1'b0; burst_mode = 1'b0;

        // Mid-run retune 64 -> 128, then retune to 0 on a wrap cycle
        en = 1'b1;
        step();
        step();
        tw_in = 8'd128; tw_vld = 1'b1;
        step();
        tw_vld = 1'b0;
        check("hs_rdy_low", tw_rdy, 0);
        check("hs_tw_old", tw_cur, 64);
        step();
        check("hs_rdy_low2", tw_rdy, 0);
        step();
        check("hs_tw_new", tw_cur, 128);
        check("hs_rdy_high", tw_rdy, 1);
        check("hs_wrap_pulse", cyc_pulse, 1);
        check("hs_wrap_clk", clk_out, 0);
        step();
        check("hs_clk_t5", clk_out, 1);
        step();
        check("hs_clk_t6", clk_out, 0);
        check("hs_pulse_t6", cyc_pulse, 1);
        step();
        check("hs_clk_t7", clk_out, 1);
        tw_in = 8'd0; tw_vld = 1'b1;
        step();
        tw_vld = 1'b0;
        check("tw0_wrapcap_tw", tw_cur, 128);
        check("tw0_wrapcap_rdy", tw_rdy, 0);
        step();
        step();
        check("tw0_applied", tw_cur, 0);
        check("tw0_rdy", tw_rdy, 1);
        step();
        step();
        check("tw0_frozen_busy", busy, 1);
        check("tw0_frozen_pulse", cyc_pulse, 0);
        check("tw0_frozen_clk", clk_out, 0);
        en = 1'b0;
        step();
        check("tw0_stop_idle", busy, 0);

        // Asynchronous reset with a word pending
        load_tw(64);
        en = 1'b1;
        step();
        step();
        step();
        tw_in = 8'd32; tw_vld = 1'b1;
        step();
        tw_vld = 1'b0;
        check("arst_pre_rdy", tw_rdy, 0);
        check("arst_pre_clk", clk_out, 1);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_clk", clk_out, 0);
        check("arst_pulse", cyc_pulse, 0);
        check("arst_busy", busy, 0);
        check("arst_rdy", tw_rdy, 1);
        check("arst_tw", tw_cur, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0; en = 1'b0;
        step();
        step();
        check("arst_pend_gone", tw_cur, 0);

        // Randomized run against the reference model
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            burst_mode = ($urandom_range(0, 2) == 0);
            burst_len  = BW'($urandom_range(0, 5));
            tw_vld     = ($urandom_range(0, 5) == 0);
            tw_in      = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 255));
            step();
            check("rnd_clk", clk_out, m_phase >= Half);
            check("rnd_pulse", cyc_pulse, m_pulse);
            check("rnd_busy", busy, m_active);
            check("rnd_rdy", tw_rdy, !m_pend);
            check("rnd_tw", tw_cur, m_tw);
        end
        model_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
